// File: rtl/rgb_fade_engine.sv
// rgb_fade_engine: colour register bank for the LED driver path.
// CH channels of W bits (channel 0 in bits [W-1:0]); each channel can be loaded,
// stepped up/down by STEP with saturation, or faded toward a target colour at a
// programmable rate. color_out feeds the PWM duty inputs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load, data_in         load the packed colour (highest priority, aborts a fade)
//   step_en, dir          one saturating step of every channel (IDLE only), dir=1 subtracts
//   fade_start, target_in start or retarget a fade toward the packed target colour
//   tick_div              fade update every tick_div+1 cycles
//   color_out             registered current colour
//   busy                  high while fading
//   done                  one-cycle pulse when a fade reaches its target
module rgb_fade_engine #(
    parameter int unsigned CH    = 3,
    parameter int unsigned W     = 8,
    parameter int unsigned STEP  = 10,
    parameter int unsigned DIV_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CH*W-1:0]   data_in,
    input  logic              step_en,
    input  logic              dir,
    input  logic              fade_start,
    input  logic [CH*W-1:0]   target_in,
    input  logic [DIV_W-1:0]  tick_div,
    output logic [CH*W-1:0]   color_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = CH * W;
    localparam logic [W:0] STEP_X = (W+1)'(STEP);
    localparam logic [W:0] MAX_X  = {1'b0, {W{1'b1}}};

    typedef enum logic {IDLE, FADE} state_t;

    state_t           state;
    logic [CW-1:0]    target;
    logic [DIV_W-1:0] presc;
    logic [CW-1:0]    step_color;
    logic [CW-1:0]    fade_color;
    logic             tick_c;

    // A count above tick_div (tick_div lowered mid-count) also triggers an update.
    assign tick_c = (presc >= tick_div);

    // Per-channel next values for a saturating step and for one fade move.
    // Arithmetic is done in W+1 bits so nothing wraps.
    always_comb begin
        logic [W:0] cur;
        logic [W:0] tgt;
        logic [W:0] sum;
        logic [W:0] nxt;
        step_color = '0;
        fade_color = '0;
        cur = '0;
        tgt = '0;
        sum = '0;
        nxt = '0;
        for (int c = 0; c < int'(CH); c++) begin
            cur = {1'b0, color_out[c*W +: W]};
            tgt = {1'b0, target[c*W +: W]};
            sum = cur + STEP_X;
            if (dir) begin
                step_color[c*W +: W] = (cur >= STEP_X) ? W'(cur - STEP_X) : '0;
            end else begin
                step_color[c*W +: W] = (sum > MAX_X) ? W'(MAX_X) : W'(sum);
            end
            if (tgt > cur) begin
                nxt = ((tgt - cur) > STEP_X) ? (cur + STEP_X) : tgt;
            end else begin
                nxt = ((cur - tgt) > STEP_X) ? (cur - STEP_X) : tgt;
            end
            fade_color[c*W +: W] = W'(nxt);
        end
    end

    // Control FSM with registered outputs; priority load > fade_start > step/fade.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            color_out <= '0;
            target    <= '0;
            presc     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                color_out <= data_in;
                state     <= IDLE;
                busy      <= 1'b0;
            end else if (fade_start) begin
                target <= target_in;
                presc  <= '0;
                if (state == IDLE && color_out == target_in) begin
                    // Already at target: report completion without entering FADE.
                    done <= 1'b1;
                end else begin
                    state <= FADE;
                    busy  <= 1'b1;
                end
            end else if (state == IDLE) begin
                if (step_en) begin
                    color_out <= step_color;
                end
            end else begin
                if (tick_c) begin
                    presc     <= '0;
                    color_out <= fade_color;
                    if (fade_color == target) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    presc <= presc + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Bench for rgb_fade_engine: behavioural colour model with per-cycle comparison,
// directed literal checks, randomized traffic and a second wide-channel instance.
module tb_rgb_fade_engine;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [23:0] data_in;
    logic        step_en;
    logic        dir;
    logic        fade_start;
    logic [23:0] target_in;
    logic [15:0] tick_div;
    logic [23:0] color_out;
    logic        busy;
    logic        done;

    logic        load2;
    logic [39:0] data2;
    logic        step2;
    logic        dir2;
    logic        fade2;
    logic [39:0] target2;
    logic [15:0] tick2;
    logic [39:0] color2;
    logic        busy2;
    logic        done2;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit check_en = 0;

    rgb_fade_engine dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .step_en(step_en),
        .dir(dir), .fade_start(fade_start), .target_in(target_in), .tick_div(tick_div),
        .color_out(color_out), .busy(busy), .done(done)
    );

    rgb_fade_engine #(.CH(4), .W(10), .STEP(1), .DIV_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load2), .data_in(data2), .step_en(step2),
        .dir(dir2), .fade_start(fade2), .target_in(target2), .tick_div(tick2),
        .color_out(color2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: three integer channels, fade flag, target, rate counter.
    int m_col[3];
    int m_tgt[3];
    int m_presc;
    bit m_fade;
    bit m_done;

    function automatic logic [23:0] mpack();
        return {8'(m_col[2]), 8'(m_col[1]), 8'(m_col[0])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                m_col[c] = 0;
                m_tgt[c] = 0;
            end
            m_presc = 0;
            m_fade  = 0;
            m_done  = 0;
        end else begin
            m_done = 0;
            if (load) begin
                for (int c = 0; c < 3; c++) m_col[c] = int'(data_in[c*8 +: 8]);
                m_fade = 0;
            end else if (fade_start) begin
                for (int c = 0; c < 3; c++) m_tgt[c] = int'(target_in[c*8 +: 8]);
                m_presc = 0;
                if (!m_fade && m_col == m_tgt) m_done = 1;
                else m_fade = 1;
            end else if (!m_fade) begin
                if (step_en) begin
                    for (int c = 0; c < 3; c++) begin
                        if (dir) m_col[c] = (m_col[c] - 10 < 0) ? 0 : m_col[c] - 10;
                        else     m_col[c] = (m_col[c] + 10 > 255) ? 255 : m_col[c] + 10;
                    end
                end
            end else if (m_presc >= int'(tick_div)) begin
                m_presc = 0;
                for (int c = 0; c < 3; c++) begin
                    int d;
                    d = m_tgt[c] - m_col[c];
                    if (d > 10)  d = 10;
                    if (d < -10) d = -10;
                    m_col[c] = m_col[c] + d;
                end
                if (m_col == m_tgt) begin
                    m_fade = 0;
                    m_done = 1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && check_en) begin
            chk("cyc_color", 64'(color_out), 64'(mpack()));
            chk("cyc_busy", 64'(busy), 64'(m_fade));
            chk("cyc_done", 64'(done), 64'(m_done));
        end
    end

    always @(negedge clk) if (rst_n && done) done_cnt++;

    task automatic idle_in();
        load = 0; step_en = 0; dir = 0; fade_start = 0;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int dc;
    int cycles;

    initial begin
        rst_n = 0;
        load = 0; data_in = '0; step_en = 0; dir = 0; fade_start = 0; target_in = '0;
        tick_div = '0;
        load2 = 0; data2 = '0; step2 = 0; dir2 = 0; fade2 = 0; target2 = '0; tick2 = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_color", 64'(color_out), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
            chk("rst_done", 64'(done), 64'h0);
            load = 1'($urandom); data_in = 24'($urandom); step_en = 1'($urandom);
            fade_start = 1'($urandom); target_in = 24'($urandom); dir = 1'($urandom);
        end
        idle_in();
        rst_n = 1;
        check_en = 1;
        cyc(1);

        // Load and saturating steps.
        load = 1; data_in = {8'd250, 8'd5, 8'd128};
        cyc(1); idle_in();
        chk("t2_load", 64'(color_out), 64'hFA0580);
        step_en = 1; dir = 0;
        cyc(1);
        chk("t2_up", 64'(color_out), 64'hFF0F8A);
        chk("t2_up_model", 64'(mpack()), 64'hFF0F8A);
        dir = 1;
        cyc(1);
        chk("t2_dn1", 64'(color_out), 64'hF50580);
        cyc(1); idle_in();
        chk("t2_dn2", 64'(color_out), 64'hEB0076);
        chk("t2_dn2_model", 64'(mpack()), 64'hEB0076);

        // Timed fade, tick_div=3.
        load = 1; data_in = '0;
        cyc(1); idle_in();
        fade_start = 1; target_in = {8'd25, 8'd10, 8'd0}; tick_div = 16'd3;
        cyc(1); fade_start = 0;
        chk("t3_busy", 64'(busy), 64'h1);
        cyc(3);
        chk("t3_hold", 64'(color_out), 64'h0);
        cyc(1);
        chk("t3_u1", 64'(color_out), 64'h0A0A00);
        chk("t3_u1_model", 64'(mpack()), 64'h0A0A00);
        cyc(4);
        chk("t3_u2", 64'(color_out), 64'h140A00);
        cyc(4);
        chk("t3_u3", 64'(color_out), 64'h190A00);
        chk("t3_done", 64'(done), 64'h1);
        chk("t3_busy_low", 64'(busy), 64'h0);
        cyc(1);
        chk("t3_done_once", 64'(done), 64'h0);

        // Retarget mid-fade.
        load = 1; data_in = '0; tick_div = 16'd0;
        cyc(1); idle_in();
        fade_start = 1; target_in = 24'h323232;
        cyc(1); fade_start = 0;
        cyc(2);
        chk("t4_mid", 64'(color_out), 64'h141414);
        #1 dc = done_cnt;
        fade_start = 1; target_in = 24'h0;
        cyc(1); fade_start = 0;
        cycles = 0;
        while (busy && cycles < 20) begin
            cyc(1);
            cycles++;
        end
        cyc(1);
        #1;
        chk("t4_back", 64'(color_out), 64'h0);
        chk("t4_one_done", 64'(done_cnt - dc), 64'h1);

        // Abort by load.
        fade_start = 1; target_in = 24'hC8C8C8;
        cyc(1); fade_start = 0;
        cyc(2);
        #1 dc = done_cnt;
        load = 1; data_in = 24'h010203;
        cyc(1); idle_in();
        chk("t4_abort_color", 64'(color_out), 64'h010203);
        chk("t4_abort_busy", 64'(busy), 64'h0);
        cyc(5);
        #1;
        chk("t4_abort_nodone", 64'(done_cnt - dc), 64'h0);

        // Null fade.
        fade_start = 1; target_in = 24'h010203;
        cyc(1); fade_start = 0;
        chk("t5_done", 64'(done), 64'h1);
        chk("t5_busy", 64'(busy), 64'h0);
        cyc(1);
        chk("t5_done_off", 64'(done), 64'h0);
        chk("t5_busy_off", 64'(busy), 64'h0);

        // Randomized traffic checked by the per-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            load = (r < 3);
            fade_start = (r >= 3 && r < 9);
            step_en = ($urandom_range(0, 99) < 30);
            dir = 1'($urandom);
            data_in = 24'($urandom);
            case ($urandom_range(0, 3))
                0: target_in = 24'($urandom);
                1: target_in = mpack();
                default: target_in = mpack() ^ (24'($urandom) & 24'h1F1F1F);
            endcase
            if ($urandom_range(0, 9) == 0) tick_div = 16'($urandom_range(0, 5));
            cyc(1);
        end
        idle_in();

        // Asynchronous reset mid-cycle during a fade.
        load = 1; data_in = 24'h090909;
        cyc(1); idle_in();
        fade_start = 1; target_in = 24'hFFFFFF; tick_div = 16'd2;
        cyc(1); fade_start = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_color", 64'(color_out), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_done", 64'(done), 64'h0);
        @(negedge clk);
        rst_n = 1;
        cyc(1);

        // Wide instance: CH=4, W=10, STEP=1, tick_div=0.
        load2 = 1; data2 = '0;
        cyc(1); load2 = 0;
        #1 dc = done_cnt;
        fade2 = 1; target2 = {40{1'b1}}; tick2 = 16'd0;
        cyc(1); fade2 = 0;
        cycles = 0;
        while (!done2 && cycles < 2000) begin
            cyc(1);
            cycles++;
        end
        chk("t6_cycles", 64'(cycles), 64'd1023);
        chk("t6_color", 64'(color2), 64'hFF_FFFF_FFFF);
        chk("t6_busy", 64'(busy2), 64'h0);
        cyc(1);
        chk("t6_done_once", 64'(done2), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
